// File: rtl/serial_subtractor_fsm.sv
// Bit-serial WIDTH-bit subtractor, LSB first.
// A full-subtract cell is stepped across the word one bit per clock, with the
// borrow carried in a flop. The start/ready/done handshake wraps the sequencing.
module serial_subtractor_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter must hold 0..WIDTH-1; never narrower than one bit.
    localparam int CNT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic load;
    logic step;
    logic last_bit;
    logic d;
    logic bn;

    // Difference bit of the full-subtract cell.
    function automatic logic sub_bit(input logic x, input logic y, input logic bin);
        return x ^ y ^ bin;
    endfunction

    // Borrow out of the full-subtract cell.
    function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    assign d        = sub_bit(sa[0], sb[0], br);
    assign bn       = sub_borrow(sa[0], sb[0], br);
    assign last_bit = (cnt == LAST);

    // Result shifts right with the new bit entering at the MSB; a one-bit
    // word has nothing to shift, so it simply takes the new bit.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_next = d;
        end else begin : g_res_multi
            assign res_next = {d, res[WIDTH-1:1]};
        end
    endgenerate

    // Outputs decoded from state only; no input reaches an output combinationally.
    assign ready = (state != SHIFT);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand/result shift registers, borrow flop, bit counter and output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_next;
            br  <= bn;
            cnt <= cnt + CNT_W'(1);
            if (last_bit) begin
                diff       <= res_next;
                borrow_out <= bn;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Self-checking bench for serial_subtractor_fsm: directed cases plus randomized
// operations at WIDTH=8, and an exhaustive sweep on a WIDTH=4 instance.
module tb_serial_subtractor_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ready4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrow4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_subtractor_fsm #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_subtractor_fsm #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .a          (a4),
        .b          (b4),
        .ready      (ready4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (borrow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; optional noise scrambles a/b/start during SHIFT.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit noise, input string tag);
        int         cyc;
        logic [7:0] exp_d;
        logic       exp_b;
        exp_d = av - bv;
        exp_b = (av < bv);
        cyc = 0;
        while (!ready && cyc < 50) begin
            tick();
            cyc++;
        end
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            if (noise) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, cyc, 8);
        check({tag, "_done"}, done, 1);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_diff"}, diff, exp_d);
        check({tag, "_borrow"}, borrow_out, exp_b);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv);
        int cyc;
        cyc = 0;
        while (!ready4 && cyc < 30) begin
            tick();
            cyc++;
        end
        start4 = 1'b1;
        a4     = av;
        b4     = bv;
        tick();
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("w4_latency", cyc, 4);
        check("w4_diff", diff4, 32'((av - bv) & 4'hF));
        check("w4_borrow", borrow4, 32'(av < bv));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);

        op8(8'd25, 8'd10, 1'b0, "basic");
        op8(8'd10, 8'd25, 1'b0, "underflow");
        op8(8'd0, 8'd1, 1'b0, "zero_minus_one");
        op8(8'd0, 8'd0, 1'b0, "zero_zero");

        // Start pulse during SHIFT must be ignored.
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd100;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("hold_done", done, 1);
        check("hold_diff", diff, 99);
        check("hold_borrow", borrow_out, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_done", done, 1);
            check("idle_diff", diff, 99);
        end

        // Back-to-back: start held in DONE is accepted immediately.
        start = 1'b1;
        a     = 8'd255;
        b     = 8'd255;
        tick();
        start = 1'b0;
        check("b2b_done_drop", done, 0);
        check("b2b_busy", busy, 1);
        repeat (7) tick();
        check("b2b_not_yet", done, 0);
        tick();
        check("b2b_done", done, 1);
        check("b2b_diff", diff, 0);
        check("b2b_borrow", borrow_out, 0);

        // Reset during SHIFT aborts the operation.
        start = 1'b1;
        a     = 8'd3;
        b     = 8'd200;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        op8(8'd7, 8'd3, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            op8(8'($urandom), 8'($urandom), 1'b1, "rand");
        end

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op4(4'(i), 4'(j));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_fsm.md
Name: serial_subtractor_fsm

Overview:
- Bit-serial N-bit subtractor, LSB first, built around the half-subtractor/borrow cell.
- Each cycle it feeds one operand bit pair plus the registered borrow through a full-subtract cell and registers the result bit.
- Sits downstream of the single-bit subtractor cell and sequences it across a word.
- Start/ready/done handshake for a control FSM or testbench driver.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- ready  output  1  high in IDLE and DONE, low in SHIFT.
- busy  output  1  high in SHIFT only.
- done  output  1  high in DONE; held until the next accepted start or rst.
- diff  output  WIDTH  (a-b) mod 2^WIDTH; valid while done=1.
- borrow_out  output  1  final borrow (1 iff a<b unsigned); valid while done=1.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; ready=1; busy=0; done=0; diff=0; borrow_out=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - rst overrides start on the same edge.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE or DONE with start=1:
  - Latch a into sa and b into sb.
  - Clear the borrow flop br, the counter cnt and the result shift register.
  - Go to SHIFT. done falls on this edge.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: stay in DONE. diff and borrow_out hold their values.
- SHIFT, once per edge:
  - d = sa[0] ^ sb[0] ^ br
  - bn = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - Result register shifts right with d entering at MSB. sa and sb shift right with 0 filling the MSB.
  - br = bn; cnt = cnt+1.
  - When cnt reaches WIDTH-1 on this edge (last bit): load diff from the final result, set borrow_out = bn, go to DONE.
- start is ignored in SHIFT. a and b may change freely in SHIFT with no effect.
- Latency: start accepted at edge k gives done=1 after edge k+WIDTH. diff is valid in that same cycle.
- Throughput: start held high in DONE is accepted immediately. This gives back-to-back operations every WIDTH+1 cycles, including one DONE cycle.
- WIDTH=1: exactly one SHIFT cycle. cnt is ceil(log2(WIDTH+1)) bits wide, minimum 1.
- Wrap-around: the result is always modulo 2^WIDTH. borrow_out is the only indication of underflow.
- rst in mid-SHIFT: the operation is aborted with no done pulse and outputs are cleared next cycle. The block is accepting again one cycle after rst deasserts.

Test Plan:
- Basic subtract: rst for 2 cycles, then start with a=25, b=10 (WIDTH=8).
  - busy=1 for exactly 8 cycles.
  - Then done=1, diff=15, borrow_out=0, ready=1.
- Underflow: a=10, b=25 -> diff=241, borrow_out=1.
- Zero operand:
  - a=0, b=1 -> diff=255, borrow_out=1.
  - a=0, b=0 -> diff=0, borrow_out=0.
- Busy and input hold:
  - Pulse start at cycle 3 of SHIFT with a=200, b=100 while the first op is a=100, b=1.
  - The pulse is ignored; result is diff=99, borrow_out=0.
  - done stays high over 5 idle cycles with diff unchanged.
- Back-to-back: hold start=1 through the DONE cycle with new a=255, b=255.
  - done drops the next cycle.
  - 8 cycles later diff=0, borrow_out=0.
  - Exhaustive sweep at WIDTH=4 matches reference arithmetic for all 256 pairs.
- Reset mid-operation: assert rst at SHIFT cycle 4.
  - Next cycle: ready=1, busy=0, done=0, diff=0.
  - A fresh start with a=7, b=3 completes with diff=4 and no stale borrow.
